// File: rtl/sha256_serial_add_ctrl.sv
// Nibble-serial multi-operand modulo-2^32 adder controller for SHA-256 T1-style sums.
// One 4-bit carry-lookahead adder is reused for every nibble of every operand.

module fourbit_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       carry_in,
    output logic [3:0] result,
    output logic       carry_out,
    output logic       g,
    output logic       p
);
    logic [3:0] gen;
    logic [3:0] prop;
    logic       c1;
    logic       c2;
    logic       c3;

    assign gen  = a & b;
    assign prop = a ^ b;

    assign c1 = gen[0] | (prop[0] & carry_in);
    assign c2 = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & carry_in);
    assign c3 = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
              | (prop[2] & prop[1] & prop[0] & carry_in);

    assign g = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
             | (prop[3] & prop[2] & prop[1] & gen[0]);
    assign p = &prop;

    assign carry_out = g | (p & carry_in);
    assign result    = prop ^ {c3, c2, c1, carry_in};
endmodule

module sha256_serial_add_ctrl #(
    parameter int MAX_OPS = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op_count,
    input  logic [31:0] op_in,
    input  logic        op_valid,
    output logic        op_ready,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] sum
);
    // state   | meaning
    // IDLE    | waiting for start; sum holds the last result
    // WAIT_OP | waiting for the next operand transfer
    // ADD     | one nibble of accumulator + operand per cycle, idx 0..7
    // DONE    | one-cycle done pulse, then back to IDLE
    typedef enum logic [1:0] {IDLE, WAIT_OP, ADD, DONE} state_t;

    state_t      state;
    logic [31:0] acc;
    logic [31:0] operand;
    logic [2:0]  idx;
    logic [2:0]  remaining;
    logic        carry;
    logic        first;

    logic [4:0]  nib_base;
    logic [3:0]  add_a;
    logic [3:0]  add_b;
    logic [3:0]  add_result;
    logic        add_cout;
    logic [1:0]  adder_gp_unused;
    logic        transfer;
    logic        count_legal;

    assign nib_base    = {idx, 2'b00};
    assign add_a       = acc[nib_base +: 4];
    assign add_b       = operand[nib_base +: 4];
    assign op_ready    = (state == WAIT_OP);
    assign busy        = (state != IDLE);
    assign transfer    = op_valid & op_ready;
    assign count_legal = (op_count >= 3'd2) && (int'(op_count) <= MAX_OPS);
    assign sum         = acc;

    fourbit_adder u_adder (
        .a         (add_a),
        .b         (add_b),
        .carry_in  (carry),
        .result    (add_result),
        .carry_out (add_cout),
        .g         (adder_gp_unused[1]),
        .p         (adder_gp_unused[0])
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            acc       <= '0;
            operand   <= '0;
            idx       <= '0;
            remaining <= '0;
            carry     <= 1'b0;
            first     <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (count_legal) begin
                            state     <= WAIT_OP;
                            remaining <= op_count;
                            first     <= 1'b1;
                            acc       <= '0;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                WAIT_OP: begin
                    if (transfer) begin
                        remaining <= remaining - 3'd1;
                        // The first operand seeds the accumulator directly, no add needed.
                        if (first) begin
                            acc   <= op_in;
                            first <= 1'b0;
                        end else begin
                            operand <= op_in;
                            idx     <= '0;
                            carry   <= 1'b0;
                            state   <= ADD;
                        end
                    end
                end
                ADD: begin
                    acc[nib_base +: 4] <= add_result;
                    carry              <= add_cout;
                    idx                <= idx + 3'd1;
                    if (idx == 3'd7) begin
                        if (remaining == 3'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= WAIT_OP;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/sha256_serial_add_ctrl.md
SHA256_SERIAL_ADD_CTRL -- requirements
Module: sha256_serial_add_ctrl

Interface
REQ-001 Parameter MAX_OPS, default 5: maximum operands per summation (SHA-256 T1 = h + Sigma1 + Ch + K + W); legal range 2..7.
REQ-002 Clk  input  1  single clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset; one clock, reset is synchronous and active-high.
REQ-004 Start  input  1  request a new summation; sampled only in IDLE.
REQ-005 OpCount  input  3  number of operands, latched on accepted Start.
REQ-006 OpIn  input  32  operand word.
REQ-007 OpValid  input  1  OpIn valid.
REQ-008 OpReady  output  1  block accepts OpIn this cycle; transfer = OpValid & OpReady.
REQ-009 Busy  output  1  high in every state except IDLE.
REQ-010 Done  output  1  one-cycle pulse, Sum final.
REQ-011 Error  output  1  one-cycle pulse, illegal OpCount on Start.
REQ-012 Sum  output  32  modulo-2^32 result; held until next accepted Start or Reset.

Function
REQ-013 Datapath SHALL be exactly one FourbitAdder instance, nibble-serial; G/P outputs unused; no other adder permitted.
REQ-014 Registers: 32-bit accumulator (drives Sum), 32-bit operand register, 3-bit nibble index, 1-bit carry register, 3-bit remaining-operand counter, first-operand flag.
REQ-015 States: IDLE, WAIT_OP, ADD, DONE.
REQ-016 IDLE: Start=1 with 2 <= OpCount <= MAX_OPS -> WAIT_OP next cycle; counter <= OpCount, first flag set, accumulator cleared to 0.
REQ-017 IDLE: Start=1 with OpCount < 2 or > MAX_OPS -> Error=1 next cycle for one cycle, stay IDLE, Sum unchanged.
REQ-018 OpReady SHALL be 1 only in WAIT_OP (combinational from state).
REQ-019 WAIT_OP, transfer with first flag set: accumulator <= OpIn, counter decrements, first flag clears, stay WAIT_OP.
REQ-020 WAIT_OP, transfer with first flag clear: operand register <= OpIn, counter decrements, nibble index <= 0, carry <= 0, -> ADD.
REQ-021 WAIT_OP with OpValid=0: hold all state indefinitely (no timeout).
REQ-022 ADD, each cycle: adder A = accumulator nibble[idx], B = operand nibble[idx], CarryIn = carry register; accumulator nibble[idx] <= Result, carry <= CarryOut, idx increments; exactly 8 cycles per operand.
REQ-023 ADD at idx=7: CarryOut discarded (mod 2^32); -> DONE if counter = 0, else -> WAIT_OP.
REQ-024 DONE: Done=1 for one cycle, -> IDLE; Sum equals the final accumulator during and after the Done cycle.
REQ-025 Latency with OpValid held high: Start sampled at cycle 0 -> Done high at cycle 2 + 9*(N-1), N = OpCount (N=2: cycle 11; N=5: cycle 38); each OpValid-low cycle in WAIT_OP adds one cycle.
REQ-026 Start asserted while Busy SHALL be ignored; no effect on state, Error, or the sum.
REQ-027 OpValid asserted outside WAIT_OP SHALL be ignored; no operand consumed.
REQ-028 Sum SHALL not change during IDLE or DONE except through a Start or Reset.

Reset
REQ-029 Reset=1 at a rising edge: state <= IDLE; Sum, operand register, counter, index, carry <= 0; OpReady, Busy, Done, Error = 0 the following cycle.
REQ-030 Reset SHALL override all other inputs, including simultaneous Start or transfer; a summation interrupted by Reset is abandoned, no Done is generated.

Verification
REQ-031 OpCount=2, ops 0xFFFFFFFF, 0x00000001, OpValid always 1 -> Sum=0x00000000, Done at cycle 11, Error never 1.
REQ-032 OpCount=2, ops 0x6A09E667, 0xBB67AE85 -> Sum=0x257194EC; ops 0x0000000F, 0x00000001 -> Sum=0x00000010, covering the carry across a nibble boundary.
REQ-033 OpCount=5, ops 1, 2, 3, 4, 5 back-to-back -> Sum=0x0000000F, Done at cycle 38, OpReady high exactly 5 cycles.
REQ-034 OpCount=3, OpValid dropped for 3 cycles before the third operand -> Done at cycle 23; Start pulsed mid-ADD has no effect.
REQ-035 Start with OpCount=1, then OpCount=6 (MAX_OPS=5) -> Error one-cycle pulse each time, Busy stays 0, Sum unchanged.
REQ-036 Reset asserted in ADD at idx=4 -> next cycle IDLE, Sum=0, Busy=0, no Done; a following OpCount=2 run produces the correct sum.
